// File: rtl/rf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wr_arb
//  Purpose  : Write-port arbiter/sequencer for an 8 x 16-bit register file.
//             Requester A (pipeline writeback) has priority.
//             Requester B (multi-cycle unit) is buffered in a 2-entry
//             shift-compacting queue.
//             Write-after-write order is preserved: an A grant squashes
//             older queued B writes to the same register.
//             A starvation counter forces a B grant after STARVE_MAX cycles.
//  Ports    : clk, rst (sync, active-low)
//             a_valid_i/a_sel_i/a_data_i -> a_ready_o
//             b_valid_i/b_sel_i/b_data_i -> b_ready_o
//             rf_write_o/rf_writeregsel_o/rf_writedata_o : registered write port
//             pend_mask_o : registers with a write queued or on the port
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wr_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid_i,
  input  logic [2:0]  a_sel_i,
  input  logic [15:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [2:0]  b_sel_i,
  input  logic [15:0] b_data_i,
  output logic        b_ready_o,
  output logic        rf_write_o,
  output logic [2:0]  rf_writeregsel_o,
  output logic [15:0] rf_writedata_o,
  output logic [7:0]  pend_mask_o
);

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  // Queue storage; slot 0 is the head (oldest entry).
  logic [1:0]        vld_q, vld_d;
  logic [1:0][2:0]   sel_q, sel_d;
  logic [1:0][15:0]  dat_q, dat_d;
  logic [3:0]        wait_q, wait_d;

  // Registered write port.
  logic              wr_q, wr_d;
  logic [2:0]        wsel_q, wsel_d;
  logic [15:0]       wdat_q, wdat_d;

  logic              force_w;
  logic              a_gnt_w;
  logic              b_gnt_w;
  logic              enq_w;
  logic              sq0_w;
  logic              sq1_w;
  logic              keep0_w;
  logic              keep1_w;

  always_comb begin
    force_w   = vld_q[0] & (wait_q == STARVE_LIM);
    a_ready_o = rst & ~force_w;
    a_gnt_w   = a_valid_i & a_ready_o;
    b_gnt_w   = vld_q[0] & ~a_gnt_w;

    // The queue compacts toward slot 0, so count < 2 is simply "slot 1 empty".
    b_ready_o = rst & ~vld_q[1];
    enq_w     = b_valid_i & b_ready_o;

    // Squash only looks at entries present at the start of the cycle; a B
    // entry enqueued this cycle is younger than the A write and survives.
    sq0_w   = a_gnt_w & vld_q[0] & (sel_q[0] == a_sel_i);
    sq1_w   = a_gnt_w & vld_q[1] & (sel_q[1] == a_sel_i);
    keep0_w = vld_q[0] & ~b_gnt_w & ~sq0_w;
    keep1_w = vld_q[1] & ~sq1_w;

    vld_d = 2'b00;
    sel_d = sel_q;
    dat_d = dat_q;
    if (keep0_w) begin
      vld_d[0] = 1'b1;
      if (keep1_w) begin
        vld_d[1] = 1'b1;
      end else if (enq_w) begin
        vld_d[1] = 1'b1;
        sel_d[1] = b_sel_i;
        dat_d[1] = b_data_i;
      end
    end else if (keep1_w) begin
      vld_d[0] = 1'b1;
      sel_d[0] = sel_q[1];
      dat_d[0] = dat_q[1];
      if (enq_w) begin
        vld_d[1] = 1'b1;
        sel_d[1] = b_sel_i;
        dat_d[1] = b_data_i;
      end
    end else if (enq_w) begin
      vld_d[0] = 1'b1;
      sel_d[0] = b_sel_i;
      dat_d[0] = b_data_i;
    end

    // Starvation counter tracks how long the current head has been waiting.
    if (~vld_q[0] | b_gnt_w | sq0_w) begin
      wait_d = 4'd0;
    end else if (wait_q != STARVE_LIM) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    // Output stage: sel/data hold when idle, only the enable drops.
    wr_d   = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (a_gnt_w) begin
      wr_d   = 1'b1;
      wsel_d = a_sel_i;
      wdat_d = a_data_i;
    end else if (b_gnt_w) begin
      wr_d   = 1'b1;
      wsel_d = sel_q[0];
      wdat_d = dat_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 2'b00;
      sel_q  <= '0;
      dat_q  <= '0;
      wait_q <= 4'd0;
      wr_q   <= 1'b0;
      wsel_q <= 3'd0;
      wdat_q <= 16'd0;
    end else begin
      vld_q  <= vld_d;
      sel_q  <= sel_d;
      dat_q  <= dat_d;
      wait_q <= wait_d;
      wr_q   <= wr_d;
      wsel_q <= wsel_d;
      wdat_q <= wdat_d;
    end
  end

  always_comb begin
    pend_mask_o = 8'h00;
    if (vld_q[0]) pend_mask_o[sel_q[0]] = 1'b1;
    if (vld_q[1]) pend_mask_o[sel_q[1]] = 1'b1;
    if (wr_q)     pend_mask_o[wsel_q]   = 1'b1;
  end

  assign rf_write_o       = wr_q;
  assign rf_writeregsel_o = wsel_q;
  assign rf_writedata_o   = wdat_q;

endmodule
`default_nettype wire

// File: doc/rf_wr_arb.md
# rf_wr_arb

Write-port arbiter and sequencer for the 8×16-bit register file. Shares the file's single write port between two requesters:
- **A**: pipeline writeback, priority.
- **B**: multi-cycle unit results, buffered in a 2-entry queue.

It orders writes so that a younger write to a register is never overwritten by an older one. It exports a pending-write mask to the hazard/stall logic.

## Interface
- `STARVE_MAX`, default 4: cycles a buffered B entry may wait before A is held off for one cycle. Legal range is 1–15.
- `clk` in, 1: clock; all state changes on the rising edge.
- `rst` in, 1: synchronous, active-low reset.
- `a_valid` in, 1: A has a write this cycle.
- `a_sel` in, 3: A destination register.
- `a_data` in, 16: A write data.
- `a_ready` out, 1: A accepted (granted) this cycle when `a_valid & a_ready`.
- `b_valid` in, 1: B offers a write.
- `b_sel` in, 3: B destination register.
- `b_data` in, 16: B write data.
- `b_ready` out, 1: queue can accept; enqueue when `b_valid & b_ready`.
- `rf_write` out, 1: register file write enable.
- `rf_writeregsel` out, 3: register file write select.
- `rf_writedata` out, 16: register file write data.
- `pend_mask` out, 8: bit i set while a write to register i is queued or on the write port.

## Operation
- **State**
  - Queue: 2 entries {valid, sel, data}, head = oldest, shift-compacting.
  - 4-bit `wait_cnt`.
  - Output register: `rf_write`, `rf_writeregsel`, `rf_writedata`.
- **Grant selection, per cycle, combinational from state**
  - `force = (queue head valid) & (wait_cnt == STARVE_MAX)`.
  - `a_ready = rst & ~force`.
  - A is granted when `a_valid & a_ready`.
  - The B head is granted when the head is valid and A is not granted.
  - At most one grant per cycle.
- **Output stage**
  - The granted {sel, data} loads the output register with `rf_write=1`.
  - With no grant, `rf_write=0`; sel and data hold their previous values.
- **Enqueue**
  - `b_ready = rst & (queue count < 2)`, computed from registered count only, with no same-cycle drain credit.
  - An accepted B entry is appended behind any surviving entries.
- **Squash (WAW ordering)**
  - When A is granted with `a_sel == s`, every queue entry already present at the start of the cycle with sel `s` is invalidated and the queue compacts.
  - A B entry enqueued in the same cycle as the A grant is younger than A and is kept.
- **Starvation counter**
  - Reset to 0 when the queue head is granted, when the queue is empty, or when the head is squashed.
  - Otherwise it increments each cycle the head is valid and not granted, saturating at `STARVE_MAX`.
- **`pend_mask`**: OR of one-hot(sel) over valid queue entries, plus one-hot(`rf_writeregsel`) when `rf_write=1`.
- **Reset** (`rst` low at an edge)
  - Queue is cleared and `wait_cnt=0`.
  - `rf_write=0`, `rf_writeregsel=0`, `rf_writedata=0`.
  - While `rst` is low: `a_ready=0`, `b_ready=0`, `pend_mask=0` after the first edge.
  - Reset mid-operation discards queued B writes and an in-flight port write. Requesters must re-issue.

## Timing
- **A latency**
  - A granted in cycle n gives `rf_write=1` with A's sel/data in cycle n+1.
  - The register file captures at the end of n+1.
  - The new value is readable from n+2.
- **B latency, minimum**
  - Enqueue in n, head grant in n+1, port write in n+2.
- **Worst-case B wait**
  - Head valid at cycle h with A continuously valid: grant is forced at h+`STARVE_MAX`, and `a_ready=0` in that cycle only.
- **Ordering is preserved across the port.**
  - If the output stage holds a B write to r while A is granted to r, the B write occurs in cycle n and the A write in n+1.
- **Queue full** (count 2): `b_ready=0`.
  - A head grant in cycle n lowers the count, so `b_ready=1` in n+1.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles with `a_valid=1`, `b_valid=1` → `a_ready=0`, `b_ready=0`, `rf_write=0`, `rf_writeregsel=0`, `rf_writedata=0`, `pend_mask=0x00`. Release → `a_ready=1`, `b_ready=1`.
- **A path:** `a_sel=3`, `a_data=0x1234` in cycle n → cycle n+1 has `rf_write=1`, sel 3, data 0x1234, `pend_mask=0x08`. Cycle n+2 has `rf_write=0`, `pend_mask=0x00`.
- **B path:** A idle, enqueue `b_sel=5`, `b_data=0xBEEF` at n → `pend_mask=0x20` in n+1; port writes sel 5 / 0xBEEF in n+2.
- **Starvation:** `STARVE_MAX=4`, A valid every cycle with distinct sels ≠ 6, B enqueues sel 6 / 0x0F0F at n.
  - `a_ready=0` only in n+5.
  - Port shows sel 6 / 0x0F0F in n+6.
  - A resumes with `a_ready=1` in n+6.
- **Squash:** A busy, B enqueues sel 2 / 0x1111, then A is granted sel 2 / 0x2222.
  - The B entry never appears on the port.
  - Queue count drops by 1.
  - Final r2 read = 0x2222.
  - Same-cycle variant: A sel 2 / 0x2222 and B enqueue sel 2 / 0x3333 together → port order 0x2222 then 0x3333; final r2 = 0x3333.
- **Full queue:** A busy, two B enqueues → `b_ready=0` with the third `b_valid` held. After the forced head grant, `b_ready=1` the next cycle and the third entry is accepted. All three values are written in enqueue order.
